// File: rtl/frame_dump_pkg.sv
// Shared types and constants for the frame buffer dump streamer.
// Header bytes are only consumed when FRAME_DUMP_HEADER_EN is defined.
package frame_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HDR,
        ST_READ,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_FIN
    } state_t;

    localparam logic [7:0] HDR_B0 = 8'hA5;
    localparam logic [7:0] HDR_B1 = 8'h5A;

    localparam int FRAME_W_DEF = 320;
    localparam int FRAME_H_DEF = 240;

    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

    function automatic int last_pixel(input int w, input int h);
        return (w * h) - 1;
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Splits a 16-bit word into high then low byte over a valid/ready stream.
// The word is held in pix_q, so tx_data cannot change while a byte waits.
module byte_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] word,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        lo_phase
);

    logic [15:0] pix_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q    <= '0;
            tx_valid <= 1'b0;
            lo_phase <= 1'b0;
        end else if (load) begin
            pix_q    <= word;
            tx_valid <= 1'b1;
            lo_phase <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            if (!lo_phase) begin
                lo_phase <= 1'b1;
            end else begin
                tx_valid <= 1'b0;
                lo_phase <= 1'b0;
            end
        end
    end

    assign tx_data = lo_phase ? pix_q[7:0] : pix_q[15:8];

endmodule

// File: rtl/frame_dump_streamer.sv
// Dumps the camera frame buffer as a byte stream (RGB565, high byte first).
// Define FRAME_DUMP_HEADER_EN to prefix the stream with A5 5A W H.
module frame_dump_streamer
    import frame_dump_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int FRAME_H    = FRAME_H_DEF,
    parameter int ADDR_W     = 17,
    parameter int RD_LAT     = 1,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              saving,
    output logic [ADDR_W-1:0] save_rAddr,
    input  logic [15:0]       ram_rData,
    output logic              freeze_req,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(last_pixel(FRAME_W, FRAME_H));
    localparam logic [7:0]        CNT_SETTLE = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]        CNT_RD     = 8'(RD_LAT - 1);
`ifdef FRAME_DUMP_HEADER_EN
    localparam logic [7:0]        HDR_B2     = 8'(FRAME_W);
    localparam logic [7:0]        HDR_B3     = 8'(FRAME_H);
    logic hdr_second;
`endif

    state_t      state;
    logic [7:0]  cnt;
    logic        last_pix;
    logic        ser_load;
    logic [15:0] ser_word;
    logic        ser_lo;
    logic        accept;

    assign accept = tx_valid && tx_ready;

    // The read address advances when the high byte leaves, so the RAM already
    // sees the next address during SEND_LO and READ lasts only RD_LAT cycles.
    always_comb begin
        ser_load = 1'b0;
        ser_word = ram_rData;
        case (state)
            ST_READ: ser_load = (cnt == CNT_RD);
`ifdef FRAME_DUMP_HEADER_EN
            ST_SETTLE: begin
                if (cnt == CNT_SETTLE) begin
                    ser_load = 1'b1;
                    ser_word = {HDR_B0, HDR_B1};
                end
            end
            ST_HDR: begin
                if (accept && ser_lo && !hdr_second) begin
                    ser_load = 1'b1;
                    ser_word = {HDR_B2, HDR_B3};
                end
            end
`endif
            default: ser_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_pix   <= 1'b0;
            save_rAddr <= '0;
            saving     <= 1'b0;
            freeze_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_second <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        cnt        <= '0;
                        saving     <= 1'b1;
                        freeze_req <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_SETTLE) begin
                        cnt <= '0;
`ifdef FRAME_DUMP_HEADER_EN
                        state      <= ST_HDR;
                        hdr_second <= 1'b0;
`else
                        state <= ST_READ;
`endif
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef FRAME_DUMP_HEADER_EN
                ST_HDR: begin
                    if (accept && ser_lo) begin
                        if (hdr_second) state <= ST_READ;
                        else            hdr_second <= 1'b1;
                    end
                end
`endif
                ST_READ: begin
                    if (cnt == CNT_RD) begin
                        cnt   <= '0;
                        state <= ST_SEND_HI;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_SEND_HI: begin
                    if (accept && !ser_lo) begin
                        state <= ST_SEND_LO;
                        if (save_rAddr == LAST_ADDR) last_pix <= 1'b1;
                        else                         save_rAddr <= save_rAddr + 1'b1;
                    end
                end
                ST_SEND_LO: begin
                    if (accept && ser_lo) begin
                        if (last_pix) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_FIN: begin
                    state      <= ST_IDLE;
                    saving     <= 1'b0;
                    freeze_req <= 1'b0;
                    busy       <= 1'b0;
                    save_rAddr <= '0;
                    last_pix   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    byte_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .word     (ser_word),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .lo_phase (ser_lo)
    );

endmodule

// File: tb/tb_frame_dump_streamer.sv
// Directed bench: a small 4x2 frame (RD_LAT=1) and a 16x8 frame (RD_LAT=2).
// Expects the A5 5A W H prefix when FRAME_DUMP_HEADER_EN is defined.
module tb_frame_dump_streamer;

    localparam int AW = 4;
    localparam int AH = 2;
    localparam int BW = 16;
    localparam int BH = 8;
`ifdef FRAME_DUMP_HEADER_EN
    localparam int HDR_N = 4;
`else
    localparam int HDR_N = 0;
`endif
    localparam int A_NB   = HDR_N + 2 * AW * AH;
    localparam int B_NB   = HDR_N + 2 * BW * BH;
    localparam int A_BUSY = 4 + HDR_N + 3 * AW * AH + 1;
    localparam int B_BUSY = 4 + HDR_N + 4 * BW * BH + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_start = 1'b0, b_start = 1'b0;
    logic        a_saving, b_saving, a_freeze, b_freeze;
    logic [16:0] a_addr, b_addr;
    logic [15:0] a_ram, b_ram;
    logic [7:0]  a_tx_data, b_tx_data;
    logic        a_tx_valid, b_tx_valid;
    logic        a_tx_ready = 1'b1, b_tx_ready = 1'b1;
    logic        a_busy, b_busy, a_done, b_done;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    frame_dump_streamer #(.FRAME_W(AW), .FRAME_H(AH), .ADDR_W(17), .RD_LAT(1), .SETTLE_CYC(4)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .saving(a_saving), .save_rAddr(a_addr),
        .ram_rData(a_ram), .freeze_req(a_freeze), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .busy(a_busy), .done(a_done));

    frame_dump_streamer #(.FRAME_W(BW), .FRAME_H(BH), .ADDR_W(17), .RD_LAT(2), .SETTLE_CYC(4)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .saving(b_saving), .save_rAddr(b_addr),
        .ram_rData(b_ram), .freeze_req(b_freeze), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .busy(b_busy), .done(b_done));

    // Synchronous RAM models returning base + address after RD_LAT cycles
    logic [15:0] a_pipe;
    logic [15:0] b_pipe [0:1];
    always @(posedge clk) begin
        a_pipe    <= 16'h1000 + 16'(a_addr);
        b_pipe[0] <= 16'h2000 + 16'(b_addr);
        b_pipe[1] <= b_pipe[0];
    end
    assign a_ram = a_pipe;
    assign b_ram = b_pipe[1];

    function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] hi, input int w, input int h);
        int k;
        if (idx < HDR_N) begin
            case (idx)
                0:       return 8'hA5;
                1:       return 8'h5A;
                2:       return 8'(w);
                default: return 8'(h);
            endcase
        end
        k = idx - HDR_N;
        return (k % 2 == 0) ? hi : 8'(k / 2);
    endfunction

    // Stream monitors, sampled on the falling edge
    logic [7:0] a_bytes [0:255];
    int a_nbytes = 0, a_done_cnt = 0, a_hold_err = 0, a_sav_err = 0, a_busy_cyc = 0;
    logic a_prev_stall = 1'b0;
    logic [7:0] a_prev_data = 8'h00;
    int b_nbytes = 0, b_done_cnt = 0, b_data_err = 0, b_frz_err = 0, b_busy_cyc = 0;
    logic [16:0] b_addr_at_done = '0;
    logic b_prev_done = 1'b0;

    always @(negedge clk) begin
        if (a_tx_valid && a_tx_ready) begin
            a_bytes[a_nbytes % 256] <= a_tx_data;
            a_nbytes <= a_nbytes + 1;
        end
        if (a_prev_stall && (!a_tx_valid || a_tx_data != a_prev_data)) a_hold_err <= a_hold_err + 1;
        a_prev_stall <= a_tx_valid && !a_tx_ready;
        a_prev_data  <= a_tx_data;
        if (a_busy && (!a_saving || !a_freeze)) a_sav_err <= a_sav_err + 1;
        if (a_tx_valid && !a_busy) a_sav_err <= a_sav_err + 1;
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (a_busy) a_busy_cyc <= a_busy_cyc + 1;
    end

    always @(negedge clk) begin
        if (b_tx_valid && b_tx_ready) begin
            if (b_tx_data !== exp_byte(b_nbytes, 8'h20, BW, BH)) b_data_err <= b_data_err + 1;
            b_nbytes <= b_nbytes + 1;
        end
        if (b_done) begin
            b_done_cnt     <= b_done_cnt + 1;
            b_addr_at_done <= b_addr;
            if (!b_freeze || !b_saving) b_frz_err <= b_frz_err + 1;
        end
        if (b_prev_done && (b_freeze || b_saving)) b_frz_err <= b_frz_err + 1;
        b_prev_done <= b_done;
        if (b_busy) b_busy_cyc <= b_busy_cyc + 1;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_a;
        tick;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
    endtask

    task automatic wait_a_idle;
        int n = 0;
        while (a_busy && n < 4000) begin
            tick;
            n++;
        end
        settle;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        settle;
        checks++;
        if ({a_saving, a_freeze, a_tx_valid, a_busy, a_done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000", {a_saving, a_freeze, a_tx_valid, a_busy, a_done});
        end
        checks++;
        if (a_addr !== 17'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", a_addr); end
        checks++;
        if (a_tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", a_tx_data); end
        checks++;
        if ({b_busy, b_saving, b_tx_valid} !== 3'b0) begin
            fails++;
            $display("FAIL reset_b_ctrl: got %b want 000", {b_busy, b_saving, b_tx_valid});
        end
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int base = a_nbytes, dbase = a_done_cnt, sbase = a_sav_err, cbase = a_busy_cyc;
        a_tx_ready = 1'b1;
        pulse_a;
        wait_a_idle;
        checks++;
        if (a_busy !== 1'b0) begin fails++; $display("FAIL basic_timeout: busy=%b want 0", a_busy); end
        checks++;
        if (a_nbytes - base != A_NB) begin fails++; $display("FAIL basic_count: got %0d want %0d", a_nbytes - base, A_NB); end
        for (int i = 0; i < A_NB; i++) begin
            checks++;
            if (a_bytes[(base + i) % 256] !== exp_byte(i, 8'h10, AW, AH)) begin
                fails++;
                $display("FAIL basic_byte%0d: got %h want %h", i, a_bytes[(base + i) % 256], exp_byte(i, 8'h10, AW, AH));
            end
        end
        checks++;
        if (a_done_cnt - dbase != 1) begin fails++; $display("FAIL basic_done: got %0d want 1", a_done_cnt - dbase); end
        checks++;
        if (a_sav_err != sbase) begin fails++; $display("FAIL basic_saving: got %0d errors want 0", a_sav_err - sbase); end
        checks++;
        if (a_busy_cyc - cbase != A_BUSY) begin fails++; $display("FAIL basic_cycles: got %0d want %0d", a_busy_cyc - cbase, A_BUSY); end
    endtask

    task automatic test_backpressure;
        int base = a_nbytes, dbase = a_done_cnt, hbase = a_hold_err;
        int n = 0;
        a_tx_ready = 1'b0;
        pulse_a;
        repeat (30) tick;
        settle;
        checks++;
        if ({a_tx_valid, a_saving, a_freeze, a_busy} !== 4'b1111) begin
            fails++;
            $display("FAIL stall_hold: got %b want 1111", {a_tx_valid, a_saving, a_freeze, a_busy});
        end
        checks++;
        if (a_tx_data !== exp_byte(0, 8'h10, AW, AH)) begin
            fails++;
            $display("FAIL stall_data: got %h want %h", a_tx_data, exp_byte(0, 8'h10, AW, AH));
        end
        while (a_busy && n < 4000) begin
            tick;
            a_tx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        a_tx_ready = 1'b1;
        settle;
        checks++;
        if (a_busy !== 1'b0) begin fails++; $display("FAIL bp_timeout: busy=%b want 0", a_busy); end
        checks++;
        if (a_nbytes - base != A_NB) begin fails++; $display("FAIL bp_count: got %0d want %0d", a_nbytes - base, A_NB); end
        for (int i = 0; i < A_NB; i++) begin
            checks++;
            if (a_bytes[(base + i) % 256] !== exp_byte(i, 8'h10, AW, AH)) begin
                fails++;
                $display("FAIL bp_byte%0d: got %h want %h", i, a_bytes[(base + i) % 256], exp_byte(i, 8'h10, AW, AH));
            end
        end
        checks++;
        if (a_hold_err != hbase) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", a_hold_err - hbase); end
        checks++;
        if (a_done_cnt - dbase != 1) begin fails++; $display("FAIL bp_done: got %0d want 1", a_done_cnt - dbase); end
    endtask

    task automatic test_restart;
        int base = a_nbytes, dbase = a_done_cnt;
        a_tx_ready = 1'b1;
        pulse_a;
        repeat (8) tick;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        repeat (5) tick;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        wait_a_idle;
        repeat (10) tick;
        settle;
        checks++;
        if (a_busy !== 1'b0) begin fails++; $display("FAIL restart_idle: busy=%b want 0", a_busy); end
        checks++;
        if (a_nbytes - base != A_NB) begin fails++; $display("FAIL restart_count: got %0d want %0d", a_nbytes - base, A_NB); end
        checks++;
        if (a_done_cnt - dbase != 1) begin fails++; $display("FAIL restart_done: got %0d want 1", a_done_cnt - dbase); end
        checks++;
        if (a_bytes[(base + A_NB - 1) % 256] !== exp_byte(A_NB - 1, 8'h10, AW, AH)) begin
            fails++;
            $display("FAIL restart_last: got %h want %h", a_bytes[(base + A_NB - 1) % 256], exp_byte(A_NB - 1, 8'h10, AW, AH));
        end
    endtask

    task automatic test_reset_mid;
        int base = a_nbytes, dbase = a_done_cnt;
        int n = 0;
        a_tx_ready = 1'b1;
        pulse_a;
        while (a_nbytes - base < 5 && n < 500) begin
            settle;
            n++;
        end
        checks++;
        if (a_nbytes - base < 5) begin fails++; $display("FAIL abort_progress: got %0d bytes want 5", a_nbytes - base); end
        tick;
        reset = 1'b1;
        @(posedge clk);
        settle;
        checks++;
        if ({a_saving, a_freeze, a_tx_valid, a_busy} !== 4'b0000) begin
            fails++;
            $display("FAIL abort_ctrl: got %b want 0000", {a_saving, a_freeze, a_tx_valid, a_busy});
        end
        tick;
        reset = 1'b0;
        repeat (3) tick;
        settle;
        checks++;
        if (a_done_cnt != dbase) begin fails++; $display("FAIL abort_done: got %0d want 0", a_done_cnt - dbase); end
        base  = a_nbytes;
        dbase = a_done_cnt;
        pulse_a;
        wait_a_idle;
        checks++;
        if (a_nbytes - base != A_NB) begin fails++; $display("FAIL redump_count: got %0d want %0d", a_nbytes - base, A_NB); end
        for (int i = 0; i < A_NB; i++) begin
            checks++;
            if (a_bytes[(base + i) % 256] !== exp_byte(i, 8'h10, AW, AH)) begin
                fails++;
                $display("FAIL redump_byte%0d: got %h want %h", i, a_bytes[(base + i) % 256], exp_byte(i, 8'h10, AW, AH));
            end
        end
        checks++;
        if (a_done_cnt - dbase != 1) begin fails++; $display("FAIL redump_done: got %0d want 1", a_done_cnt - dbase); end
    endtask

    task automatic test_rdlat2_frame;
        int n = 0;
        b_tx_ready = 1'b1;
        tick;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        while (b_busy && n < 4000) begin
            tick;
            n++;
        end
        settle;
        checks++;
        if (b_busy !== 1'b0) begin fails++; $display("FAIL b_timeout: busy=%b want 0", b_busy); end
        checks++;
        if (b_nbytes != B_NB) begin fails++; $display("FAIL b_count: got %0d want %0d", b_nbytes, B_NB); end
        checks++;
        if (b_data_err != 0) begin fails++; $display("FAIL b_data: got %0d bad bytes want 0", b_data_err); end
        checks++;
        if (b_addr_at_done !== 17'(BW * BH - 1)) begin
            fails++;
            $display("FAIL b_last_addr: got %0d want %0d", b_addr_at_done, BW * BH - 1);
        end
        checks++;
        if (b_frz_err != 0) begin fails++; $display("FAIL b_freeze_fall: got %0d errors want 0", b_frz_err); end
        checks++;
        if (b_done_cnt != 1) begin fails++; $display("FAIL b_done: got %0d want 1", b_done_cnt); end
        checks++;
        if (b_busy_cyc != B_BUSY) begin fails++; $display("FAIL b_cycles: got %0d want %0d", b_busy_cyc, B_BUSY); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_restart;
        test_reset_mid;
        test_rdlat2_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/frame_dump_streamer.md
Name: frame_dump_streamer

Overview:
- Downstream consumer of the camera frame buffer read port (saving / save_rAddr / ram_rData).
- On a start pulse it takes the read port away from the VGA reader and freezes camera writes.
- It then walks every pixel address and emits each RGB565 word as two bytes over a valid/ready byte stream, normally into a UART transmitter.
- It runs on the system pixel clock, the same clock as the frame buffer read side.

Parameters:
- FRAME_W, 320, pixels per line.
- FRAME_H, 240, lines per frame.
- ADDR_W, 17, width of the frame buffer address.
- RD_LAT, 1, frame buffer read latency in cycles (1..3).
- SETTLE_CYC, 4, cycles to wait after freeze_req rises before the first read.

Ports:
- clk  in  1  system clock; same clock as the frame buffer rclk.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle dump request.
- saving  out  1  high while this block owns the frame buffer read address.
- save_rAddr  out  ADDR_W  frame buffer read address.
- ram_rData  in  16  frame buffer read data, RGB565.
- freeze_req  out  1  stops camera writes; ORed with the freeze switch upstream.
- tx_data  out  8  stream byte.
- tx_valid  out  1  stream byte valid.
- tx_ready  in  1  sink accepts a byte.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values: saving=0, save_rAddr=0, freeze_req=0, tx_data=0, tx_valid=0, busy=0, done=0. State returns to IDLE.
- Reset asserted mid-dump aborts the dump on the next clock edge. No done pulse is produced.
- States and transitions:
  - IDLE: wait for start. start=1 moves to SETTLE and sets freeze_req=1 and saving=1.
  - SETTLE: count SETTLE_CYC cycles, then go to READ.
  - READ: drive save_rAddr with the current address and wait RD_LAT cycles. On the last wait cycle, latch ram_rData into pix_q. Go to SEND_HI.
  - SEND_HI: tx_data=pix_q[15:8], tx_valid=1. On tx_valid&&tx_ready, go to SEND_LO.
  - SEND_LO: tx_data=pix_q[7:0], tx_valid=1. On acceptance:
    - address == FRAME_W*FRAME_H-1: go to FIN.
    - otherwise: increment the address and go to READ.
  - FIN: done=1 for one cycle; saving=0, freeze_req=0, address=0. Go to IDLE.
- Handshake rules:
  - A transfer occurs on any cycle with tx_valid && tx_ready.
  - Once tx_valid rises, tx_valid and tx_data stay constant until the transfer.
  - tx_valid is never high outside the SEND states.
- saving and freeze_req are asserted from the cycle after start is sampled until the FIN cycle inclusive. Both drop in the cycle after FIN.
- Per-pixel throughput: RD_LAT+2 cycles minimum (tx_ready held high).
- start while busy is ignored. It is not queued.
- The address counter is ADDR_W wide and compares against FRAME_W*FRAME_H-1 (76799 at defaults). It never wraps past the frame end.
- tx_ready stuck low stalls the block indefinitely in its SEND state; saving and freeze stay held.
- The VGA image glitches while saving=1. This is accepted behaviour.

Optional Feature:
- Macro: FRAME_DUMP_HEADER_EN.
- Defined:
  - A HDR state is inserted between SETTLE and the first READ.
  - HDR sends four bytes with the same handshake: 0xA5, 0x5A, FRAME_W[7:0], FRAME_H[7:0].
  - Pixel bytes follow the header unchanged.
- Undefined: no header; the stream contains only pixel bytes, 2*FRAME_W*FRAME_H of them.

Decomposition:
- Package frame_dump_pkg:
  - state enum type;
  - header byte constants HDR_B0=8'hA5, HDR_B1=8'h5A;
  - localparam helpers for frame size and last address.
- One sub-module, byte_serializer: takes a 16-bit word plus load, and emits two bytes under the valid/ready handshake. The FSM drives it.

Test Plan:
- FRAME_W=4, FRAME_H=2, RAM model returns 16'h1000+addr, tx_ready=1, start pulse → 16 bytes in order 10 00 10 01 … 10 07; done pulses once; saving high throughout.
- Same setup, tx_ready toggled randomly → identical byte sequence; tx_data never changes while tx_valid=1 and tx_ready=0.
- start re-pulsed mid-dump → ignored; byte count remains 16; a single done.
- reset asserted after 5 bytes → next cycle saving=0, freeze_req=0, tx_valid=0, busy=0; a new start dumps from address 0.
- Default parameters with RD_LAT=2 → last save_rAddr=76799; exactly 153600 bytes; freeze_req falls the cycle after done.
- FRAME_DUMP_HEADER_EN defined, FRAME_W=4, FRAME_H=2 → stream begins A5 5A 04 02, followed by the 16 pixel bytes.
